float_to_int: RTL and testbench
===============================

Name: float_to_int

Overview:
- Converts an IEEE-754 single-precision word to a signed 32-bit two's-complement integer, rounding toward zero.
- This is the decode direction of the team's float pack/add datapath: it unpacks sign, exponent and mantissa, then aligns the mantissa with an iterative multi-cycle shifter.
- Sits between the operand memory (mem1) read path and integer consumers.
- Uses a valid/ready handshake on both sides.

Parameters:
SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
BIAS, 127, exponent bias.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept; high only in IDLE
in_data  input  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] fraction
out_valid  output  1  result is valid; held until out_ready
out_ready  input  1  consumer accepts the result
out_data  output  32  signed integer result
out_overflow  output  1  magnitude out of range, or ±Inf; result saturated
out_inexact  output  1  nonzero bits were discarded by truncation
out_invalid  output  1  input was NaN

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, all flags 0. Reset mid-operation abandons the conversion; the block is back in IDLE on the next cycle.
- States: IDLE, SHIFT, FIX, OUT.
- IDLE: on in_valid && in_ready, register the unpacked fields:
  - m = {1, frac} (24 bits); e = exp - BIAS.
  - Classify the input. Special or degenerate cases go straight to OUT on the next edge with the result and flags set:
    - exp=255, frac≠0 (NaN): out_data=0x80000000, invalid=1.
    - exp=255, frac=0 (±Inf): out_data=0x7FFFFFFF (+) or 0x80000000 (−), overflow=1.
    - exp=0 (zero/denormal): out_data=0; inexact = (frac≠0).
    - e<0: out_data=0, inexact=1.
    - e≥31: saturate as for ±Inf with overflow=1. Exception: sign=1, exp=158, frac=0 is exactly −2^31, which converts normally with no overflow.
  - Otherwise go to SHIFT with dir = (e≥23 ? left : right) and cnt = |e−23|.
- SHIFT:
  - Each cycle shifts a 32-bit magnitude register by min(SHIFT_STEP, cnt) and decrements cnt by the same amount.
  - On right shifts, OR every discarded bit into a sticky bit; sticky becomes out_inexact.
  - When cnt=0 on entry or after the update, go to FIX. cnt≤23, so at most ceil(23/SHIFT_STEP) cycles.
- FIX: one cycle. out_data = sign ? −mag : mag, truncated to 32 bits. Go to OUT.
- OUT: out_valid=1, with out_data and flags stable.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
  - No new input is accepted in the same cycle as the out handshake.
- Latency from accepting edge to out_valid high:
  - normal path: ceil(k/SHIFT_STEP)+2 edges, with k=|e−23|;
  - special path: 1 edge.
- Arithmetic: the magnitude register is 32 bits unsigned. A left shift never exceeds bit 31, because e≤30 on the normal path except the −2^31 case, which yields mag=0x80000000; negating that gives 0x80000000.
- Flags are registered alongside out_data and cleared on every new accept.
- in_ready is 0 in SHIFT, FIX and OUT. in_data changes outside IDLE are ignored.

Decomposition:
- Package fp_pkg holds:
  - field positions and widths (SIGN_BIT, EXP_MSB/LSB, FRAC_W=23, MANT_W=24);
  - BIAS and EXP_ALL_ONES=255;
  - INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000;
  - the state enum {IDLE, SHIFT, FIX, OUT}.
- One sub-module, fp_unpack: combinational. Takes the 32-bit word; outputs sign, e (signed 9 bits), m, and class flags is_nan, is_inf, is_zero_or_denorm. It is reusable by the adder datapath.

Test Plan:
- 0x41280000 (10.5), SHIFT_STEP=1 -> out_data=0x0000000A, inexact=1, out_valid 22 edges after accept (k=20).
- 0xC0E80000 (−7.25) -> 0xFFFFFFF9, inexact=1. Then 0x40500000 (3.25) back-to-back, with out_ready held low 5 cycles -> out_data held stable, in_ready=0 throughout, then 0x00000003.
- 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1, 1-edge latency. 0xCF000000 (−2^31) -> 0x80000000, overflow=0, inexact=0.
- 0x7FC00000 (NaN) -> 0x80000000, invalid=1. 0xFF800000 (−Inf) -> 0x80000000, overflow=1. 0x80000000 (−0) -> 0, no flags. 0x00000001 (denormal) -> 0, inexact=1.
- 0x3F000000 (0.5) -> 0, inexact=1. 0x4B000001 (8388609.0, k=0) -> 0x00800001, inexact=0, 2-edge latency. SHIFT_STEP=8 with 10.5 -> same result, 5-edge latency.
- Assert rst during SHIFT of 10.5 -> next cycle state=IDLE, out_valid=0, in_ready=1. A following 3.25 converts correctly to 3.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout, integer limits and converter
// state encoding for the float pack/add/convert datapath.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;

  localparam int              BIAS         = 127;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'd255;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Smaller of the remaining shift count and the per-cycle step.
  function automatic logic [4:0] step_amount(input logic [4:0] cnt, input logic [4:0] step);
    return (cnt < step) ? cnt : step;
  endfunction

endpackage

// File: rtl/float_to_int_if.sv
// Valid/ready handshake bundle for the float-to-integer converter: float word in,
// saturated integer plus exception flags out.
interface float_to_int_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_inexact;
  logic        out_invalid;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_inexact, out_invalid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_inexact, out_invalid
  );

endinterface

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpacker: sign, unbiased exponent, mantissa with
// hidden one, and the special-value classes shared with the adder datapath.
module fp_unpack #(
  parameter int BIAS = fp_pkg::BIAS
) (
  input  logic [31:0]       word,
  output logic              sign,
  output logic signed [8:0] e,
  output logic [23:0]       m,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero_or_denorm
);
  import fp_pkg::*;

  logic [EXP_W-1:0]  exp_s;
  logic [FRAC_W-1:0] frac_s;

  // Field split and classification of the incoming word.
  always_comb begin
    exp_s             = word[EXP_MSB:EXP_LSB];
    frac_s            = word[FRAC_W-1:0];
    sign              = word[SIGN_BIT];
    e                 = 9'($signed({1'b0, exp_s}) - $signed(9'(BIAS)));
    m                 = {1'b1, frac_s};
    is_nan            = (exp_s == EXP_ALL_ONES) && (frac_s != 23'd0);
    is_inf            = (exp_s == EXP_ALL_ONES) && (frac_s == 23'd0);
    is_zero_or_denorm = (exp_s == 8'd0);
  end

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero, with an
// iterative SHIFT_STEP-bits-per-cycle mantissa aligner and saturation flags.
module float_to_int #(
  parameter int SHIFT_STEP = 1,
  parameter int BIAS       = fp_pkg::BIAS
) (
  input  logic           clk,
  input  logic           rst,
  float_to_int_if.slave  bus
);
  import fp_pkg::*;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic              sign_s;
  logic signed [8:0] e_s;
  logic [23:0]       m_s;
  logic              is_nan_s;
  logic              is_inf_s;
  logic              is_zd_s;

  state_t      state_r;
  logic [31:0] mag_r;
  logic [4:0]  cnt_r;
  logic        dir_left_r;
  logic        sign_r;
  logic        sticky_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] out_data_r;
  logic        overflow_r;
  logic        inexact_r;
  logic        invalid_r;

  logic signed [8:0] diff_s;
  logic [4:0]        k_s;
  logic              exact_min_s;
  logic [4:0]        amt_s;
  logic [4:0]        cnt_next_s;
  logic [31:0]       discard_mask_s;

  fp_unpack #(.BIAS(BIAS)) u_unpack (
    .word              (bus.in_data),
    .sign              (sign_s),
    .e                 (e_s),
    .m                 (m_s),
    .is_nan            (is_nan_s),
    .is_inf            (is_inf_s),
    .is_zero_or_denorm (is_zd_s)
  );

  // Alignment distance for a new operand and per-cycle shift bookkeeping.
  always_comb begin
    diff_s         = e_s - 9'sd23;
    k_s            = diff_s[8] ? 5'(9'sd0 - diff_s) : 5'(diff_s);
    exact_min_s    = sign_s && (e_s == 9'sd31) && (m_s == 24'h80_0000);
    amt_s          = step_amount(cnt_r, STEP);
    cnt_next_s     = cnt_r - amt_s;
    discard_mask_s = (32'd1 << amt_s) - 32'd1;
  end

  // Converter FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mag_r       <= 32'd0;
      cnt_r       <= 5'd0;
      dir_left_r  <= 1'b0;
      sign_r      <= 1'b0;
      sticky_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      overflow_r  <= 1'b0;
      inexact_r   <= 1'b0;
      invalid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            overflow_r <= 1'b0;
            inexact_r  <= 1'b0;
            invalid_r  <= 1'b0;
            sticky_r   <= 1'b0;
            sign_r     <= sign_s;
            mag_r      <= {8'd0, m_s};
            dir_left_r <= ~diff_s[8];
            cnt_r      <= k_s;
            if (is_nan_s) begin
              out_data_r  <= INT_MIN;
              invalid_r   <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= OUT;
            end else if (is_inf_s || (e_s >= 9'sd31 && !exact_min_s)) begin
              out_data_r  <= sign_s ? INT_MIN : INT_MAX;
              overflow_r  <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= OUT;
            end else if (is_zd_s || e_s < 9'sd0) begin
              out_data_r  <= 32'd0;
              inexact_r   <= is_zd_s ? (m_s[22:0] != 23'd0) : 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= OUT;
            end else begin
              // An already aligned mantissa skips the shifter entirely.
              state_r <= (k_s == 5'd0) ? FIX : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (dir_left_r) begin
            mag_r <= mag_r << amt_s;
          end else begin
            mag_r    <= mag_r >> amt_s;
            sticky_r <= sticky_r | (|(mag_r & discard_mask_s));
          end
          cnt_r <= cnt_next_s;
          if (cnt_next_s == 5'd0) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          out_data_r  <= sign_r ? (32'd0 - mag_r) : mag_r;
          inexact_r   <= sticky_r;
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_overflow = overflow_r;
  assign bus.out_inexact  = inexact_r;
  assign bus.out_invalid  = invalid_r;

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: SHIFT_STEP=1 and SHIFT_STEP=8 instances,
// checking results, flags, latency, output hold and mid-conversion reset.
module tb_float_to_int;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_to_int_if bus1 ();
  float_to_int_if bus8 ();

  float_to_int #(.SHIFT_STEP(1)) dut_1 (.clk(clk), .rst(rst), .bus(bus1));
  float_to_int #(.SHIFT_STEP(8)) dut_8 (.clk(clk), .rst(rst), .bus(bus8));

  // flags packed as {overflow, inexact, invalid}
  typedef struct {
    logic [31:0] word;
    logic [31:0] data;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    int          lat;
    bit          stable;
    bit          busy_ok;
  } obs_t;

  vec_t sb[$];
  int   total  = 0;
  int   passed = 0;

  // Drive one word into the selected DUT and observe its result handshake.
  task automatic xfer(input bit sel, input logic [31:0] w, input int hold, output obs_t o);
    logic [31:0] first;
    int n;
    o.stable  = 1'b1;
    o.busy_ok = 1'b1;
    if (sel) begin bus8.in_valid = 1'b1; bus8.in_data = w; end
    else     begin bus1.in_valid = 1'b1; bus1.in_data = w; end
    n = 0;
    while (!(sel ? bus8.in_ready : bus1.in_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    o.lat = 1;
    while (!(sel ? bus8.out_valid : bus1.out_valid) && o.lat < 200) begin
      if (sel ? bus8.in_ready : bus1.in_ready) o.busy_ok = 1'b0;
      @(posedge clk); #1; o.lat++;
    end
    first = sel ? bus8.out_data : bus1.out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if ((sel ? bus8.out_data : bus1.out_data) !== first) o.stable = 1'b0;
      if ((sel ? bus8.in_ready : bus1.in_ready) !== 1'b0) o.busy_ok = 1'b0;
      if ((sel ? bus8.out_valid : bus1.out_valid) !== 1'b1) o.stable = 1'b0;
    end
    if (sel ? bus8.in_ready : bus1.in_ready) o.busy_ok = 1'b0;
    o.data  = sel ? bus8.out_data : bus1.out_data;
    o.flags = sel ? {bus8.out_overflow, bus8.out_inexact, bus8.out_invalid}
                  : {bus1.out_overflow, bus1.out_inexact, bus1.out_invalid};
    if (sel) bus8.out_ready = 1'b1; else bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus1.in_ready !== 1'b1) $display("FAIL reset_in_ready1 got %b want 1", bus1.in_ready); else passed++;
    total++; if (bus1.out_valid !== 1'b0) $display("FAIL reset_out_valid1 got %b want 0", bus1.out_valid); else passed++;
    total++; if (bus1.out_data !== 32'd0) $display("FAIL reset_out_data1 got %h want 0", bus1.out_data); else passed++;
    total++;
    if ({bus1.out_overflow, bus1.out_inexact, bus1.out_invalid} !== 3'b000)
      $display("FAIL reset_flags1 got %b want 000", {bus1.out_overflow, bus1.out_inexact, bus1.out_invalid});
    else passed++;
    total++; if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready8 got %b want 1", bus8.in_ready); else passed++;
    total++; if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid8 got %b want 0", bus8.out_valid); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_normal();
    vec_t v[3];
    vec_t e;
    obs_t o;
    v = '{'{32'h4128_0000, 32'h0000_000A, 3'b010, 22},
          '{32'h4B00_0001, 32'h0080_0001, 3'b000, 2},
          '{32'hCF00_0000, 32'h8000_0000, 3'b000, 10}};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(v[i]);
      xfer(1'b0, v[i].word, 0, o);
      e = sb.pop_front();
      total++; if (o.data !== e.data) $display("FAIL normal_data[%h] got %h want %h", e.word, o.data, e.data); else passed++;
      total++; if (o.flags !== e.flags) $display("FAIL normal_flags[%h] got %b want %b", e.word, o.flags, e.flags); else passed++;
      total++; if (o.lat !== e.lat) $display("FAIL normal_latency[%h] got %0d want %0d", e.word, o.lat, e.lat); else passed++;
      total++; if (o.busy_ok !== 1'b1) $display("FAIL normal_busy_ready[%h] got %b want 1", e.word, o.busy_ok); else passed++;
    end
  endtask

  task automatic test_specials();
    vec_t v[6];
    vec_t e;
    obs_t o;
    v = '{'{32'h4F00_0000, 32'h7FFF_FFFF, 3'b100, 1},
          '{32'h7FC0_0000, 32'h8000_0000, 3'b001, 1},
          '{32'hFF80_0000, 32'h8000_0000, 3'b100, 1},
          '{32'h8000_0000, 32'h0000_0000, 3'b000, 1},
          '{32'h0000_0001, 32'h0000_0000, 3'b010, 1},
          '{32'h3F00_0000, 32'h0000_0000, 3'b010, 1}};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(v[i]);
      xfer(1'b0, v[i].word, 0, o);
      e = sb.pop_front();
      total++; if (o.data !== e.data) $display("FAIL special_data[%h] got %h want %h", e.word, o.data, e.data); else passed++;
      total++; if (o.flags !== e.flags) $display("FAIL special_flags[%h] got %b want %b", e.word, o.flags, e.flags); else passed++;
      total++; if (o.lat !== e.lat) $display("FAIL special_latency[%h] got %0d want %0d", e.word, o.lat, e.lat); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[2];
    vec_t e;
    obs_t o;
    v = '{'{32'hC0E8_0000, 32'hFFFF_FFF9, 3'b010, 23},
          '{32'h4050_0000, 32'h0000_0003, 3'b010, 24}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(v[i]);
      xfer(1'b0, v[i].word, (i == 1) ? 5 : 0, o);
      e = sb.pop_front();
      total++; if (o.data !== e.data) $display("FAIL b2b_data[%h] got %h want %h", e.word, o.data, e.data); else passed++;
      total++; if (o.flags !== e.flags) $display("FAIL b2b_flags[%h] got %b want %b", e.word, o.flags, e.flags); else passed++;
      total++; if (o.lat !== e.lat) $display("FAIL b2b_latency[%h] got %0d want %0d", e.word, o.lat, e.lat); else passed++;
      total++; if (o.stable !== 1'b1) $display("FAIL b2b_hold_stable[%h] got %b want 1", e.word, o.stable); else passed++;
      total++; if (o.busy_ok !== 1'b1) $display("FAIL b2b_in_ready_low[%h] got %b want 1", e.word, o.busy_ok); else passed++;
    end
  endtask

  task automatic test_step8();
    vec_t v[4];
    vec_t e;
    obs_t o;
    v = '{'{32'h4128_0000, 32'h0000_000A, 3'b010, 5},
          '{32'hC0E8_0000, 32'hFFFF_FFF9, 3'b010, 5},
          '{32'hCF00_0000, 32'h8000_0000, 3'b000, 3},
          '{32'h4B00_0001, 32'h0080_0001, 3'b000, 2}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(v[i]);
      xfer(1'b1, v[i].word, 0, o);
      e = sb.pop_front();
      total++; if (o.data !== e.data) $display("FAIL step8_data[%h] got %h want %h", e.word, o.data, e.data); else passed++;
      total++; if (o.flags !== e.flags) $display("FAIL step8_flags[%h] got %b want %b", e.word, o.flags, e.flags); else passed++;
      total++; if (o.lat !== e.lat) $display("FAIL step8_latency[%h] got %0d want %0d", e.word, o.lat, e.lat); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    vec_t e;
    obs_t o;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 32'h4128_0000;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (dut_1.state_r !== IDLE) $display("FAIL rst_mid_state got %0d want %0d", dut_1.state_r, IDLE); else passed++;
    total++; if (bus1.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", bus1.out_valid); else passed++;
    total++; if (bus1.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", bus1.in_ready); else passed++;
    v = '{32'h4050_0000, 32'h0000_0003, 3'b010, 24};
    sb.push_back(v);
    xfer(1'b0, v.word, 0, o);
    e = sb.pop_front();
    total++; if (o.data !== e.data) $display("FAIL rst_mid_next_data got %h want %h", o.data, e.data); else passed++;
    total++; if (o.flags !== e.flags) $display("FAIL rst_mid_next_flags got %b want %b", o.flags, e.flags); else passed++;
    total++; if (o.lat !== e.lat) $display("FAIL rst_mid_next_latency got %0d want %0d", o.lat, e.lat); else passed++;
  endtask

  initial begin
    rst            = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 32'd0;
    bus1.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = 32'd0;
    bus8.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_specials();
    test_back_to_back();
    test_step8();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
